// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control FSM for the multicycle RV32I core. Sequences the shared ALU,
// instruction register, PC, register file, unified memory and immediate
// extender for lw, sw, R-type ALU, I-type ALU and beq. Any other opcode is
// flagged illegal in DECODE and skipped.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   op, funct3,     instruction fields from the instruction register
//   funct7b5
//   Zero            ALU zero flag (qualifies the beq PC write)
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc, RegWrite   datapath selects and write enables
//   retire          one-cycle pulse in the last state of a legal instruction
//   illegal         one-cycle pulse in DECODE for an unsupported opcode
//
// Parameter MEM_WAIT (0..15) adds stall cycles to MEMREAD and MEMWRITE.
module multicycle_controller #(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       retire,
  output logic       illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ
  } state_t;

  state_t     state;
  state_t     cur;
  logic [3:0] wcnt;
  logic       wait_done;
  logic [1:0] aluop;
  logic       pcupdate;
  logic       branch;
  logic       regwrite_raw;
  logic       memwrite_raw;
  logic       irwrite_raw;
  logic       retire_raw;
  logic       illegal_raw;

  function automatic logic [2:0] alu_decode(input logic [1:0] aop,
                                            input logic [2:0] f3,
                                            input logic       opb5,
                                            input logic       f7b5);
    logic [2:0] r;
    r = 3'b000;
    case (aop)
      2'b00: r = 3'b000;
      2'b01: r = 3'b001;
      2'b10: begin
        case (f3)
          // Only R-type (op[5]=1) may subtract; addi immediates set bit 30.
          3'b000:  r = (opb5 & f7b5) ? 3'b001 : 3'b000;
          3'b010:  r = 3'b101;
          3'b110:  r = 3'b011;
          3'b111:  r = 3'b010;
          default: r = 3'b000;
        endcase
      end
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] imm_decode(input logic [6:0] opc);
    logic [1:0] r;
    case (opc)
      OP_LW, OP_I: r = 2'b00;
      OP_SW:       r = 2'b01;
      OP_BEQ:      r = 2'b10;
      default:     r = 2'b11;
    endcase
    return r;
  endfunction

  assign wait_done = (wcnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      wcnt  <= 4'd0;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECR;
            OP_I:         state <= EXECI;
            OP_BEQ:       state <= BEQ;
            default:      state <= FETCH;
          endcase
        end
        MEMADR: begin
          wcnt  <= 4'd0;
          state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
        end
        MEMREAD: begin
          if (wait_done) state <= MEMWB;
          else           wcnt  <= wcnt + 4'd1;
        end
        MEMWRITE: begin
          if (wait_done) state <= FETCH;
          else           wcnt  <= wcnt + 4'd1;
        end
        EXECR, EXECI:      state <= ALUWB;
        MEMWB, ALUWB, BEQ: state <= FETCH;
        default:           state <= FETCH;
      endcase
    end
  end

  // While in reset the selects show the FETCH decode; enables are masked below.
  assign cur = rst ? FETCH : state;

  always_comb begin
    AdrSrc       = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    aluop        = 2'b00;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    retire_raw   = 1'b0;
    illegal_raw  = 1'b0;
    case (cur)
      FETCH: begin
        irwrite_raw = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        pcupdate    = 1'b1;
      end
      DECODE: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b01;
        illegal_raw = !(op == OP_LW || op == OP_SW || op == OP_R ||
                        op == OP_I  || op == OP_BEQ);
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc    = 2'b01;
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc       = 1'b1;
        memwrite_raw = wait_done;
        retire_raw   = wait_done;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        aluop      = 2'b01;
        branch     = 1'b1;
        retire_raw = 1'b1;
      end
      default: ;
    endcase
  end

  assign ALUControl = alu_decode(aluop, funct3, op[5], funct7b5);
  assign ImmSrc     = imm_decode(op);
  assign PCWrite    = ~rst & (pcupdate | (branch & Zero));
  assign IRWrite    = ~rst & irwrite_raw;
  assign RegWrite   = ~rst & regwrite_raw;
  assign MemWrite   = ~rst & memwrite_raw;
  assign retire     = ~rst & retire_raw;
  assign illegal    = ~rst & illegal_raw;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I core. Sequences the shared ALU, instruction register, PC, register file, unified memory and the immediate extender.
- Each instruction takes 3–5 states (plus memory wait states).
- Drives every datapath select and write enable, including the 2-bit ImmSrc consumed by the immediate extender.
- Supports lw, sw, R-type ALU, I-type ALU and beq. Any other opcode is flagged illegal and skipped.

Parameters:
- MEM_WAIT, 0: extra stall cycles spent in MEMREAD and MEMWRITE (range 0–15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- op  input  7  Instr[6:0] from the instruction register.
- funct3  input  3  Instr[14:12].
- funct7b5  input  1  Instr[30].
- Zero  input  1  ALU zero flag.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0=PC, 1=Result.
- MemWrite  output  1  memory write enable.
- IRWrite  output  1  instruction register and OldPC enable.
- ResultSrc  output  2  00=ALUOut, 01=read data, 10=ALUResult.
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1.
- ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=constant 4.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc  output  2  00=I, 01=S, 10=B, 11=none (extender outputs 0).
- RegWrite  output  1  register file write enable.
- retire  output  1  one-cycle pulse in the last state of each legal instruction.
- illegal  output  1  one-cycle pulse in DECODE for an unsupported opcode.

Behaviour:
- Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ. Every output defaults to 0 unless listed for a state.
- PCWrite = PCUpdate | (Branch & Zero).
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - anything else -> FETCH, with illegal=1 in this cycle.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Held for MEM_WAIT+1 cycles by a wait counter, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1. Next state FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00 for MEM_WAIT+1 cycles. MemWrite=1 and retire=1 only in the final cycle. Next state FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1. Next state FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, retire=1. Next state FETCH.
- ALU decode (combinational):
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10 by funct3:
    - 000 -> 001 if (op[5] & funct7b5), else 000. addi with imm bit 10 set must stay add.
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
    - any other funct3 -> 000
- ImmSrc (combinational from op, every state):
  - 0000011 and 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - else -> 11
  - The value during FETCH is don't-care for the datapath but must still follow this decode.
- Wait counter: 4 bits. Loaded to 0 on entering MEMREAD/MEMWRITE. With MEM_WAIT=0 each of those states lasts exactly 1 cycle.
- Reset: rst sampled at clk. Next state is FETCH and the wait counter clears to 0. While rst=1, PCWrite, IRWrite, RegWrite, MemWrite, retire and illegal are forced to 0; the other outputs follow the FETCH decode.
- Reset mid-instruction: the instruction is abandoned with no register or memory write. The first IRWrite occurs in the first cycle with rst=0.
- Latency (MEM_WAIT=0): lw 5 cycles, sw 4, R/I-type 4, beq 3, illegal 2.

Test Plan:
- Hold rst 3 cycles, then release -> IRWrite=1 and PCWrite=1 in the first cycle after release; no write enables while rst=1.
- lw x5,8(x1) (0x0080A283), MEM_WAIT=0:
  - states FETCH, DECODE, MEMADR, MEMREAD, MEMWB in 5 cycles
  - ImmSrc=00
  - AdrSrc=1 in MEMREAD
  - RegWrite and retire only in cycle 5.
- Same lw with MEM_WAIT=2 -> MEMREAD lasts 3 cycles, 7 cycles total. sw 0x0050A423 with MEM_WAIT=2:
  - ImmSrc=01
  - MemWrite exactly 1 cycle, in the last MEMWRITE cycle.
- sub x3,x1,x2 (0x402081B3) -> ALUControl=001 in EXECR. addi x3,x1,-1024 (0xC0008193) -> ALUControl=000 in EXECI. slt/or/and funct3 -> 101/011/010.
- beq (0x00208463):
  - with Zero=1 -> PCWrite=1 in BEQ; with Zero=0 -> PCWrite=0
  - ImmSrc=10
  - 3 cycles, retire in BEQ.
- jal (0x0000006F) -> illegal=1 in DECODE, next state FETCH, no RegWrite/MemWrite. Assert rst during ALUWB -> RegWrite=0 that cycle, FETCH follows.
